// File: rtl/weight_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : weight_pingpong_buf
// Brief    : Two-bank weight store; one bank fills from the weight bus while
//            the MAC array reads the other through a registered read port.
// Revision : 1.0
// ============================================================================
module weight_pingpong_buf #(
    parameter int DATA_W = 32,
    parameter int N3     = 72,
    parameter int N1     = 8,
    parameter int RA_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       weight_waddr,
    input  logic [DATA_W-1:0] weight_wdata,
    input  logic              weight_wen,
    output logic              buf_free,
    output logic              rd_vld,
    output logic [7:0]        rd_ch,
    input  logic              rd_en,
    input  logic [RA_W-1:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_release,
    output logic              err_ovf,
    output logic              err_tag
);

    localparam int C3_W    = $clog2(N3 + 1);
    localparam int C1_W    = $clog2(N1 + 1);
    localparam int c_depth = N3 + N1;
    localparam logic [C3_W-1:0] c_n3_cnt  = C3_W'(N3);
    localparam logic [C1_W-1:0] c_n1_cnt  = C1_W'(N1);
    localparam logic [RA_W-1:0] c_n3_addr = RA_W'(N3);

    logic [DATA_W-1:0] mem_q [2][c_depth];

    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [1:0]        full_q, full_d;
    logic [1:0][7:0]   tag_q, tag_d;
    logic [C3_W-1:0]   cnt3_q, cnt3_d;
    logic [C1_W-1:0]   cnt1_q, cnt1_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_tag_q, err_tag_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              is_1x1;
    logic [7:0]        wr_tag;
    logic              room;
    logic              wr_accept;
    logic [RA_W-1:0]   wr_idx;
    logic [C3_W-1:0]   cnt3_nxt;
    logic [C1_W-1:0]   cnt1_nxt;
    logic              bank_empty;
    logic              complete;
    logic              rel;
    logic              unused_waddr;

    assign unused_waddr = ^weight_waddr[22:0];

    always_comb begin
        is_1x1     = weight_waddr[31];
        wr_tag     = weight_waddr[30:23];
        room       = is_1x1 ? (cnt1_q != c_n1_cnt) : (cnt3_q != c_n3_cnt);
        wr_accept  = weight_wen & ~full_q[wbank_q] & room;
        wr_idx     = is_1x1 ? (c_n3_addr + RA_W'(cnt1_q)) : RA_W'(cnt3_q);
        cnt3_nxt   = cnt3_q + C3_W'(wr_accept & ~is_1x1);
        cnt1_nxt   = cnt1_q + C1_W'(wr_accept & is_1x1);
        bank_empty = (cnt3_q == '0) && (cnt1_q == '0);
        complete   = wr_accept && (cnt3_nxt == c_n3_cnt) && (cnt1_nxt == c_n1_cnt);
        rel        = rd_release & full_q[rbank_q];

        wbank_d = wbank_q ^ complete;
        rbank_d = rbank_q ^ rel;
        cnt3_d  = complete ? '0 : cnt3_nxt;
        cnt1_d  = complete ? '0 : cnt1_nxt;

        // Release and completion always target different banks, so both apply.
        full_d = full_q;
        if (rel)      full_d[rbank_q] = 1'b0;
        if (complete) full_d[wbank_q] = 1'b1;

        tag_d = tag_q;
        if (wr_accept && bank_empty) tag_d[wbank_q] = wr_tag;

        err_ovf_d = err_ovf_q | (weight_wen & ~wr_accept);
        err_tag_d = err_tag_q | (wr_accept & ~bank_empty & (wr_tag != tag_q[wbank_q]));

        rd_data_d = rd_data_q;
        if (rd_en && full_q[rbank_q]) begin
            rd_data_d = (int'(rd_addr) < c_depth) ? mem_q[rbank_q][rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wbank_q][wr_idx] <= weight_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            full_q    <= '0;
            tag_q     <= '0;
            cnt3_q    <= '0;
            cnt1_q    <= '0;
            err_ovf_q <= 1'b0;
            err_tag_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            full_q    <= full_d;
            tag_q     <= tag_d;
            cnt3_q    <= cnt3_d;
            cnt1_q    <= cnt1_d;
            err_ovf_q <= err_ovf_d;
            err_tag_q <= err_tag_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign buf_free = ~full_q[wbank_q];
    assign rd_vld   = full_q[rbank_q];
    assign rd_ch    = tag_q[rbank_q];
    assign rd_data  = rd_data_q;
    assign err_ovf  = err_ovf_q;
    assign err_tag  = err_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_pingpong_buf
// Brief    : Directed bench for weight_pingpong_buf with a read-data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_weight_pingpong_buf;

    localparam int DATA_W = 32;
    localparam int N3     = 72;
    localparam int N1     = 8;
    localparam int RA_W   = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       weight_waddr;
    logic [DATA_W-1:0] weight_wdata;
    logic              weight_wen;
    logic              buf_free;
    logic              rd_vld;
    logic [7:0]        rd_ch;
    logic              rd_en;
    logic [RA_W-1:0]   rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_release;
    logic              err_ovf;
    logic              err_tag;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DATA_W-1:0] exp_q [$];

    weight_pingpong_buf #(
        .DATA_W (DATA_W),
        .N3     (N3),
        .N1     (N1),
        .RA_W   (RA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .weight_waddr (weight_waddr),
        .weight_wdata (weight_wdata),
        .weight_wen   (weight_wen),
        .buf_free     (buf_free),
        .rd_vld       (rd_vld),
        .rd_ch        (rd_ch),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_release   (rd_release),
        .err_ovf      (err_ovf),
        .err_tag      (err_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Read-data monitor: every accepted read is compared one cycle later.
    always begin
        @(posedge clk);
        if (rd_en && rd_vld && !rst) begin
            #1;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rd_data: got 0x%0h with no read expected", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic wen, input logic one, input logic [7:0] tag,
                       input logic [31:0] data, input logic ren,
                       input logic [RA_W-1:0] ra, input logic rel);
        @(negedge clk);
        weight_wen   = wen;
        weight_waddr = {one, tag, 23'h0};
        weight_wdata = data;
        rd_en        = ren;
        rd_addr      = ra;
        rd_release   = rel;
    endtask

    task automatic wr(input logic one, input logic [7:0] tag, input logic [31:0] data);
        cyc(1'b1, one, tag, data, 1'b0, '0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [RA_W-1:0] ra, input logic [31:0] exp);
        cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, ra, 1'b0);
        exp_q.push_back(exp);
    endtask

    task automatic rel_bank();
        cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, '0, 1'b1);
    endtask

    task automatic burst(input logic [7:0] tag, input logic [31:0] b3, input logic [31:0] b1);
        for (int i = 0; i < N3; i++) wr(1'b0, tag, b3 + 32'(i));
        for (int i = 0; i < N1; i++) wr(1'b1, tag, b1 + 32'(i));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; weight_wen = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; weight_wen = 1'b0; weight_waddr = '0; weight_wdata = '0;
        rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        do_reset();
        check("rst_rd_vld",   32'(rd_vld),   32'h0);
        check("rst_rd_ch",    32'(rd_ch),    32'h0);
        check("rst_rd_data",  rd_data,       32'h0);
        check("rst_err_ovf",  32'(err_ovf),  32'h0);
        check("rst_err_tag",  32'(err_tag),  32'h0);
        check("rst_buf_free", 32'(buf_free), 32'h1);

        // Single channel
        burst(8'h05, 32'h0, 32'h100);
        idle();
        check("single_rd_vld",   32'(rd_vld),   32'h1);
        check("single_rd_ch",    32'(rd_ch),    32'h05);
        check("single_buf_free", 32'(buf_free), 32'h1);
        rd(7'd71,  32'h47);
        rd(7'd72,  32'h100);
        rd(7'd100, 32'h0);
        rd(7'd79,  32'h107);
        rel_bank();
        idle();
        check("rel_rd_vld", 32'(rd_vld), 32'h0);
        cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 7'd5, 1'b0);
        idle();
        check("hold_rd_data", rd_data, 32'h107);

        // Ping-pong, back to back
        burst(8'h01, 32'h1000, 32'h1100);
        burst(8'h02, 32'h2000, 32'h2100);
        idle();
        check("pp_buf_free", 32'(buf_free), 32'h0);
        check("pp_rd_vld",   32'(rd_vld),   32'h1);
        check("pp_rd_ch",    32'(rd_ch),    32'h01);
        rd(7'd3,  32'h1003);
        rd(7'd75, 32'h1103);

        // Overflow with both banks full
        for (int i = 0; i < 3; i++) wr(1'b0, 8'h09, 32'hDEAD);
        idle();
        check("ovf_err_ovf", 32'(err_ovf), 32'h1);
        check("ovf_err_tag", 32'(err_tag), 32'h0);
        rd(7'd0,  32'h1000);
        rd(7'd71, 32'h1047);
        rel_bank();
        idle();
        check("pp2_rd_ch",    32'(rd_ch),    32'h02);
        check("pp2_buf_free", 32'(buf_free), 32'h1);
        check("pp2_rd_vld",   32'(rd_vld),   32'h1);
        rd(7'd0,  32'h2000);
        rd(7'd79, 32'h2107);
        rel_bank();
        idle();
        check("pp3_rd_vld", 32'(rd_vld), 32'h0);

        // 73rd 3x3 word within one bank
        do_reset();
        check("rst2_err_ovf", 32'(err_ovf), 32'h0);
        for (int i = 0; i < N3; i++) wr(1'b0, 8'h07, 32'h7000 + 32'(i));
        wr(1'b0, 8'h07, 32'h7FFF);
        idle();
        check("ovf73_err_ovf", 32'(err_ovf), 32'h1);
        check("ovf73_rd_vld",  32'(rd_vld),  32'h0);
        for (int i = 0; i < N1; i++) wr(1'b1, 8'h07, 32'h7100 + 32'(i));
        idle();
        check("ovf73_done_vld", 32'(rd_vld), 32'h1);
        check("ovf73_rd_ch",    32'(rd_ch),  32'h07);
        rd(7'd71, 32'h7047);
        rd(7'd72, 32'h7100);

        // Tag mismatch; 1x1 words first; final write coincides with release
        for (int i = 0; i < N1; i++) wr(1'b1, 8'h03, 32'h3100 + 32'(i));
        for (int i = 0; i < N3 - 1; i++)
            wr(1'b0, (i == 9) ? 8'h04 : 8'h03, 32'h3000 + 32'(i));
        cyc(1'b1, 1'b0, 8'h03, 32'h3047, 1'b0, '0, 1'b1);
        idle();
        check("same_rd_vld",   32'(rd_vld),   32'h1);
        check("same_rd_ch",    32'(rd_ch),    32'h03);
        check("same_buf_free", 32'(buf_free), 32'h1);
        check("tag_err_tag",   32'(err_tag),  32'h1);
        rd(7'd9,  32'h3009);
        rd(7'd72, 32'h3100);

        // Reset mid-burst
        for (int i = 0; i < 40; i++) wr(1'b0, 8'h0A, 32'hA000 + 32'(i));
        do_reset();
        check("mid_rd_vld",   32'(rd_vld),   32'h0);
        check("mid_rd_ch",    32'(rd_ch),    32'h0);
        check("mid_rd_data",  rd_data,       32'h0);
        check("mid_err_ovf",  32'(err_ovf),  32'h0);
        check("mid_err_tag",  32'(err_tag),  32'h0);
        check("mid_buf_free", 32'(buf_free), 32'h1);
        burst(8'h0B, 32'hB000, 32'hB100);
        idle();
        check("fresh_rd_vld",  32'(rd_vld),  32'h1);
        check("fresh_rd_ch",   32'(rd_ch),   32'h0B);
        check("fresh_err_ovf", 32'(err_ovf), 32'h0);
        rd(7'd0,  32'hB000);
        rd(7'd71, 32'hB047);
        rd(7'd79, 32'hB107);
        idle();
        idle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
